hyperbus_responder: RTL and testbench

Synthesizable HyperBus memory-device responder: the target end of the link driven by the `hyperbus` controller. It decodes the 48-bit command-address (CA), applies a fixed double initial latency and serves linear or wrapped bursts. Bursts go to an internal word memory or a small register space. It is used in FPGA and simulation loopback benches and sits directly on the controller's PHY-side signals (no pads). All link signals are sampled in the `clk_i` domain. One HyperBus *beat* (one CK edge) is a `clk_i` cycle in which the sampled `hyper_ck_i` differs from its value in the previous cycle.

---
 rtl/hyperbus_resp_pkg.sv | 14 +
 rtl/hyperbus_responder_if.sv | 15 +
 rtl/hyperbus_resp_mem.sv | 18 +
 rtl/hyperbus_responder.sv | 132 +++++++++++++
 tb/tb_hyperbus_responder.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/hyperbus_resp_pkg.sv
// hyperbus_resp_pkg: shared types and constants for the HyperBus responder
package hyperbus_resp_pkg;
  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [28:0] row;
    logic [12:0] rsvd;
    logic [2:0]  col;
  } hyper_ca_t;
  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGW} resp_state_e;
  localparam logic [7:0]  CaBeats = 8'd6;
  localparam logic [31:0] Cr0Addr = 32'h800;
endpackage

// File: rtl/hyperbus_responder_if.sv
// hyperbus_responder_if: PHY-side HyperBus link between controller and responder
interface hyperbus_responder_if;
  logic       hyper_cs_ni;
  logic       hyper_ck_i;
  logic [7:0] hyper_dq_i;
  logic [7:0] hyper_dq_o;
  logic       hyper_dq_oe_o;
  logic       hyper_rwds_i;
  logic       hyper_rwds_o;
  logic       hyper_rwds_oe_o;
  modport master (output hyper_cs_ni, hyper_ck_i, hyper_dq_i, hyper_rwds_i,
                  input  hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o);
  modport slave  (input  hyper_cs_ni, hyper_ck_i, hyper_dq_i, hyper_rwds_i,
                  output hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o);
endinterface

// File: rtl/hyperbus_resp_mem.sv
// hyperbus_resp_mem: 16-bit word RAM with per-byte write enables, registered write, combinational read
module hyperbus_resp_mem #(
  parameter int AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic [1:0]           we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [15:0]          wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [15:0]          rdata
);
  logic [15:0] mem [2**AddrWidth];
  always_ff @(posedge clk_i) begin
    if (we[1]) mem[waddr][15:8] <= wdata[15:8];
    if (we[0]) mem[waddr][7:0] <= wdata[7:0];
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/hyperbus_responder.sv
// hyperbus_responder: HyperBus target decoding CA, applying double latency and serving bursts to RAM or CR0
module hyperbus_responder
  import hyperbus_resp_pkg::*;
#(
  parameter int          MemAddrWidth = 10,
  parameter int          Latency      = 6,
  parameter logic [15:0] IdReg0       = 16'h0c81,
  parameter logic [15:0] Cr0Default   = 16'h8f1f
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  hyperbus_responder_if.slave  bus,
  output logic [15:0]          cr0_o
);
  localparam logic [7:0] LatBeats = 8'(4 * Latency - 6);
  resp_state_e state;
  logic        cs_s, ck_s, ck_q, rwds_s, beat;
  logic [7:0]  dq_s, cnt, hi_q, dq_q;
  logic [39:0] ca;
  hyper_ca_t   ca_nxt;
  logic [31:0] addr, addr_inc, rd_addr;
  logic        is_reg, linear, is_read, odd;
  logic        dq_oe_q, rwds_q, rwds_oe_q;
  logic [15:0] cr0, mem_rdata, rd_word;
  logic [1:0]  we;
  // Link inputs pass through one register stage so CK, DQ, RWDS and CS stay aligned
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cs_s   <= 1'b1;
      ck_s   <= 1'b0;
      ck_q   <= 1'b0;
      dq_s   <= '0;
      rwds_s <= 1'b0;
    end else begin
      cs_s   <= bus.hyper_cs_ni;
      ck_s   <= bus.hyper_ck_i;
      ck_q   <= ck_s;
      dq_s   <= bus.hyper_dq_i;
      rwds_s <= bus.hyper_rwds_i;
    end
  assign beat     = ck_s ^ ck_q;
  assign ca_nxt   = {ca, dq_s};
  assign addr_inc = linear ? addr + 32'd1 : {addr[31:4], addr[3:0] + 4'd1};
  assign rd_addr  = (state == RDATA && !rwds_q) ? addr_inc : addr;
  assign rd_word  = !is_reg ? mem_rdata : rd_addr == 32'h0 ? IdReg0 : rd_addr == Cr0Addr ? cr0 : 16'h0;
  assign we       = (state == WDATA && beat && !cs_s && !rwds_s) ? (odd ? 2'b01 : 2'b10) : 2'b00;
  hyperbus_resp_mem #(.AddrWidth(MemAddrWidth)) u_mem (
    .clk_i (clk_i),
    .we    (we),
    .waddr (addr[MemAddrWidth-1:0]),
    .wdata ({dq_s, dq_s}),
    .raddr (rd_addr[MemAddrWidth-1:0]),
    .rdata (mem_rdata)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= IDLE;
      ca        <= '0;
      cnt       <= '0;
      addr      <= '0;
      is_reg    <= 1'b0;
      linear    <= 1'b0;
      is_read   <= 1'b0;
      odd       <= 1'b0;
      hi_q      <= '0;
      cr0       <= Cr0Default;
      dq_q      <= '0;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else if (cs_s) begin
      state     <= IDLE;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= CA;
          cnt       <= '0;
          rwds_oe_q <= 1'b1;
          rwds_q    <= 1'b1;
        end
        CA: if (beat) begin
          ca  <= ca_nxt[39:0];
          cnt <= cnt + 8'd1;
          if (cnt == CaBeats - 8'd1) begin
            addr      <= {ca_nxt.row, ca_nxt.col};
            is_reg    <= ca_nxt.as;
            linear    <= ca_nxt.burst;
            is_read   <= ca_nxt.rw;
            cnt       <= '0;
            rwds_oe_q <= 1'b0;
            rwds_q    <= 1'b0;
            state     <= (!ca_nxt.rw && ca_nxt.as) ? REGW : LAT;
          end
        end
        LAT: if (beat) begin
          cnt <= cnt + 8'd1;
          odd <= 1'b0;
          if (cnt == LatBeats - 8'd1) begin
            state <= is_read ? RDATA : WDATA;
            if (is_read) begin
              dq_q      <= rd_word[15:8];
              dq_oe_q   <= 1'b1;
              rwds_oe_q <= 1'b1;
              rwds_q    <= 1'b1;
            end
          end
        end
        WDATA: if (beat) begin
          odd <= !odd;
          if (odd) addr <= addr_inc;
        end
        RDATA: if (beat) begin
          rwds_q <= !rwds_q;
          dq_q   <= rwds_q ? rd_word[7:0] : rd_word[15:8];
          if (!rwds_q) addr <= addr_inc;
        end
        REGW: if (beat && cnt < 8'd2) begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd0) hi_q <= dq_s;
          else if (addr == Cr0Addr) cr0 <= {hi_q, dq_s};
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.hyper_dq_o      = dq_q;
  assign bus.hyper_dq_oe_o   = dq_oe_q;
  assign bus.hyper_rwds_o    = rwds_q;
  assign bus.hyper_rwds_oe_o = rwds_oe_q;
  assign cr0_o               = cr0;
endmodule

// File: tb/tb_hyperbus_responder.sv
// tb_hyperbus_responder: directed HyperBus transactions against the responder with hand-computed expectations
module tb_hyperbus_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cr0;
  int          passed = 0;
  int          total = 0;
  hyperbus_responder_if bus();
  hyperbus_responder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .cr0_o  (cr0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [47:0] mk_ca(input logic rw, input logic as, input logic lin, input logic [31:0] a);
    return {rw, as, lin, a[31:3], 13'd0, a[2:0]};
  endfunction
  task automatic step(input logic [7:0] d, input logic m);
    bus.hyper_dq_i   = d;
    bus.hyper_rwds_i = m;
    bus.hyper_ck_i   = ~bus.hyper_ck_i;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic start(input logic [47:0] ca, input int nbeats);
    bus.hyper_cs_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ca_rwds_oe", bus.hyper_rwds_oe_o, 1);
    chk("ca_rwds", bus.hyper_rwds_o, 1);
    for (int i = 5; i > 5 - nbeats; i--) step(ca[i*8 +: 8], 1'b0);
  endtask
  task automatic lat();
    for (int i = 0; i < 18; i++) step(8'h00, 1'b0);
  endtask
  task automatic stop(input string tag);
    bus.hyper_cs_ni = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_dq_oe_off"}, bus.hyper_dq_oe_o, 0);
    chk({tag, "_rwds_oe_off"}, bus.hyper_rwds_oe_o, 0);
  endtask
  task automatic rd(input logic as, input logic lin, input logic [31:0] a, input int n,
                    input logic [3:0][15:0] exp, input string tag);
    start(mk_ca(1'b1, as, lin, a), 6);
    lat();
    chk({tag, "_dq_oe"}, bus.hyper_dq_oe_o, 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d_hi", tag, i), bus.hyper_dq_o, exp[i][15:8]);
      chk($sformatf("%s_w%0d_strobe_hi", tag, i), bus.hyper_rwds_o, 1);
      step(8'h00, 1'b0);
      chk($sformatf("%s_w%0d_lo", tag, i), bus.hyper_dq_o, exp[i][7:0]);
      chk($sformatf("%s_w%0d_strobe_lo", tag, i), bus.hyper_rwds_o, 0);
      if (i < n - 1) step(8'h00, 1'b0);
    end
    stop(tag);
  endtask
  initial begin
    bus.hyper_cs_ni  = 1'b1;
    bus.hyper_ck_i   = 1'b0;
    bus.hyper_dq_i   = 8'h00;
    bus.hyper_rwds_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dq", bus.hyper_dq_o, 0);
    chk("rst_dq_oe", bus.hyper_dq_oe_o, 0);
    chk("rst_rwds", bus.hyper_rwds_o, 0);
    chk("rst_rwds_oe", bus.hyper_rwds_oe_o, 0);
    chk("rst_cr0", cr0, 16'h8f1f);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start(mk_ca(1'b0, 1'b0, 1'b1, 32'h10), 6);
    lat();
    step(8'h12, 1'b0);
    step(8'h34, 1'b0);
    step(8'h56, 1'b0);
    step(8'h78, 1'b0);
    stop("wr10");
    rd(1'b0, 1'b1, 32'h10, 2, 64'h0000_0000_5678_1234, "rd10");
    start(mk_ca(1'b0, 1'b0, 1'b1, 32'h20), 6);
    lat();
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    stop("clr20");
    start(mk_ca(1'b0, 1'b0, 1'b1, 32'h20), 6);
    lat();
    step(8'hAA, 1'b0);
    step(8'hBB, 1'b1);
    stop("mask20");
    rd(1'b0, 1'b1, 32'h20, 1, 64'h0000_0000_0000_AA00, "rd20");
    start(mk_ca(1'b0, 1'b0, 1'b1, 32'h10), 6);
    lat();
    for (int i = 0; i < 16; i++) begin
      step(8'h00, 1'b0);
      step(8'(16 + i), 1'b0);
    end
    stop("fill");
    rd(1'b0, 1'b0, 32'h1E, 4, 64'h0011_0010_001F_001E, "wrap");
    start(mk_ca(1'b0, 1'b0, 1'b1, 32'h0), 6);
    lat();
    step(8'hC3, 1'b0);
    step(8'hA5, 1'b0);
    stop("wr0");
    start(mk_ca(1'b0, 1'b1, 1'b0, 32'h800), 6);
    step(8'h8f, 1'b0);
    chk("cr0_hold", cr0, 16'h8f1f);
    step(8'h17, 1'b0);
    chk("cr0_wr", cr0, 16'h8f17);
    stop("regw");
    rd(1'b1, 1'b0, 32'h000, 1, 64'h0000_0000_0000_0c81, "id0");
    rd(1'b1, 1'b0, 32'h800, 1, 64'h0000_0000_0000_8f17, "cr0rd");
    start(mk_ca(1'b0, 1'b0, 1'b1, 32'h0), 3);
    stop("abort");
    rd(1'b0, 1'b1, 32'h0, 1, 64'h0000_0000_0000_C3A5, "post_abort");
    start(mk_ca(1'b1, 1'b0, 1'b1, 32'h0), 6);
    lat();
    chk("pre_rst_dq_oe", bus.hyper_dq_oe_o, 1);
    step(8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.hyper_cs_ni = 1'b1;
    bus.hyper_ck_i  = 1'b0;
    #1;
    chk("arst_dq_oe", bus.hyper_dq_oe_o, 0);
    chk("arst_rwds_oe", bus.hyper_rwds_oe_o, 0);
    chk("arst_dq", bus.hyper_dq_o, 0);
    chk("arst_cr0", cr0, 16'h8f1f);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(1'b0, 1'b1, 32'h20, 1, 64'h0000_0000_0000_AA00, "post_rst");
    chk("post_rst_cr0", cr0, 16'h8f1f);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
